// File: rtl/move_controller.sv
// move_controller
//   Owns the chess board state array; the display path reads it in parallel.
//   Turns cursor clicks into piece moves: select a source square, select a
//   destination square, then commit. Only piece ownership is checked (no move
//   legality); a capture is simply an overwrite of the destination square.
//
// Piece codes (4 bits): 0 EMPTY; white 1..6 = PAWN, KNIGHT, BISHOP, ROOK,
//   QUEEN, KING; black = the white code with bit 3 set (9..14).
//
// Ports
//   Clk             in   system clock, all state on the rising edge
//   Reset           in   asynchronous active-high reset to the start position
//   new_game        in   synchronous reload of the start position
//   click_btn       in   left-button level, already synchronised to Clk
//   cursor_valid    in   1 = cursor is over the 8x8 board
//   cursor_squareX  in   cursor column 0..7
//   cursor_squareY  in   cursor row 0..7 (0 = top, black's back rank)
//   board           out  board[x][y] piece codes, register array
//   startX, startY  out  selected source square
//   highlight_flag  out  1 while a source square is selected
//   white_turn      out  1 = white to move
//   move_done       out  one-cycle pulse, high during the commit cycle
//   o_state         out  FSM state (0 IDLE, 1 SELECTED, 2 COMMIT)
//
// Handshake: a click event is a rising edge of click_btn seen while
//   cursor_valid=1; a held button produces exactly one event. Events arriving
//   while the FSM is in COMMIT are dropped.

module move_controller #(
  parameter logic PROMOTE_EN  = 1'b1,
  parameter logic WHITE_FIRST = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  new_game,
  input  logic                  click_btn,
  input  logic                  cursor_valid,
  input  logic [2:0]            cursor_squareX,
  input  logic [2:0]            cursor_squareY,
  output logic [7:0][7:0][3:0]  board,
  output logic [2:0]            startX,
  output logic [2:0]            startY,
  output logic                  highlight_flag,
  output logic                  white_turn,
  output logic                  move_done,
  output logic [1:0]            o_state
);

  localparam logic [3:0] EMPTY       = 4'd0;
  localparam logic [3:0] PAWN_WHITE  = 4'd1;
  localparam logic [3:0] QUEEN_WHITE = 4'd5;
  localparam logic [3:0] PAWN_BLACK  = 4'd9;
  localparam logic [3:0] QUEEN_BLACK = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_COMMIT   = 2'd2
  } state_t;

  // Back-rank piece kind (colour bit clear) for column x.
  function automatic logic [2:0] back_kind(input logic [2:0] x);
    case (x)
      3'd0, 3'd7: back_kind = 3'd4;  // rook
      3'd1, 3'd6: back_kind = 3'd2;  // knight
      3'd2, 3'd5: back_kind = 3'd3;  // bishop
      3'd3:       back_kind = 3'd5;  // queen
      default:    back_kind = 3'd6;  // king
    endcase
  endfunction

  function automatic logic [7:0][7:0][3:0] start_position();
    logic [7:0][7:0][3:0] b;
    b = '0;
    for (int x = 0; x < 8; x++) begin
      b[x][0] = {1'b1, back_kind(3'(x))};
      b[x][1] = PAWN_BLACK;
      b[x][6] = PAWN_WHITE;
      b[x][7] = {1'b0, back_kind(3'(x))};
    end
    return b;
  endfunction

  // A piece belongs to the side to move; codes 0, 7, 8 and 15 belong to nobody.
  function automatic logic is_own(input logic [3:0] p, input logic wt);
    logic kind_ok;
    kind_ok = (p[2:0] != 3'd0) && (p[2:0] != 3'd7);
    return kind_ok && (p[3] == ~wt);
  endfunction

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0][7:0][3:0] r_board;
  logic [2:0]           r_startX;
  logic [2:0]           r_startY;
  logic [2:0]           r_dstX;
  logic [2:0]           r_dstY;
  logic                 r_highlight;
  logic                 r_white_turn;
  logic                 r_move_done;
  logic                 r_btn_q;

  logic                 w_event;
  logic [3:0]           w_sq;
  logic                 w_own;
  logic                 w_on_start;
  logic [3:0]           w_src_piece;
  logic [3:0]           w_moved_piece;
  logic                 w_load_start;
  logic                 w_set_hl;
  logic                 w_clr_hl;
  logic                 w_latch_dst;
  logic                 w_commit;

  assign w_event    = click_btn && !r_btn_q && cursor_valid && (r_state != ST_COMMIT);
  assign w_sq       = r_board[cursor_squareX][cursor_squareY];
  assign w_own      = is_own(w_sq, r_white_turn);
  assign w_on_start = (cursor_squareX == r_startX) && (cursor_squareY == r_startY);

  assign w_src_piece = r_board[r_startX][r_startY];

  always_comb begin
    w_moved_piece = w_src_piece;
    if (PROMOTE_EN) begin
      if (w_src_piece == PAWN_WHITE && r_dstY == 3'd0) w_moved_piece = QUEEN_WHITE;
      if (w_src_piece == PAWN_BLACK && r_dstY == 3'd7) w_moved_piece = QUEEN_BLACK;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_start = 1'b0;
    w_set_hl     = 1'b0;
    w_clr_hl     = 1'b0;
    w_latch_dst  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_event && w_own) begin
          w_load_start = 1'b1;
          w_set_hl     = 1'b1;
          w_next_state = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (w_event) begin
          if (w_on_start) begin
            w_clr_hl     = 1'b1;
            w_next_state = ST_IDLE;
          end else if (w_own) begin
            w_load_start = 1'b1;
          end else begin
            w_latch_dst  = 1'b1;
            w_next_state = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        w_commit     = 1'b1;
        w_clr_hl     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_board      <= start_position();
      r_startX     <= 3'd0;
      r_startY     <= 3'd0;
      r_dstX       <= 3'd0;
      r_dstY       <= 3'd0;
      r_highlight  <= 1'b0;
      r_white_turn <= WHITE_FIRST;
      r_move_done  <= 1'b0;
      r_btn_q      <= 1'b0;
    end else if (new_game) begin
      r_state      <= ST_IDLE;
      r_board      <= start_position();
      r_startX     <= 3'd0;
      r_startY     <= 3'd0;
      r_dstX       <= 3'd0;
      r_dstY       <= 3'd0;
      r_highlight  <= 1'b0;
      r_white_turn <= WHITE_FIRST;
      r_move_done  <= 1'b0;
      r_btn_q      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_btn_q     <= click_btn;
      // Raised on entry to COMMIT so the pulse coincides with the commit cycle.
      r_move_done <= w_latch_dst;
      if (w_load_start) begin
        r_startX <= cursor_squareX;
        r_startY <= cursor_squareY;
      end
      if (w_latch_dst) begin
        r_dstX <= cursor_squareX;
        r_dstY <= cursor_squareY;
      end
      if (w_set_hl)      r_highlight <= 1'b1;
      else if (w_clr_hl) r_highlight <= 1'b0;
      // Source and destination never coincide: clicking the source deselects.
      if (w_commit) begin
        r_board[r_dstX][r_dstY]     <= w_moved_piece;
        r_board[r_startX][r_startY] <= EMPTY;
        r_white_turn                <= ~r_white_turn;
      end
    end
  end

  assign board          = r_board;
  assign startX         = r_startX;
  assign startY         = r_startY;
  assign highlight_flag = r_highlight;
  assign white_turn     = r_white_turn;
  assign move_done      = r_move_done;
  assign o_state        = r_state;

endmodule

// File: tb/tb_move_controller.sv
// Testbench for move_controller. Two instances share all inputs: one with
// promotion enabled, one with it disabled. Committed moves are pushed to a
// scoreboard queue as they are driven and checked when move_done pulses.

module tb_move_controller;

  localparam logic [3:0] EMPTY        = 4'd0;
  localparam logic [3:0] PAWN_WHITE   = 4'd1;
  localparam logic [3:0] KNIGHT_WHITE = 4'd2;
  localparam logic [3:0] BISHOP_WHITE = 4'd3;
  localparam logic [3:0] ROOK_WHITE   = 4'd4;
  localparam logic [3:0] QUEEN_WHITE  = 4'd5;
  localparam logic [3:0] KING_WHITE   = 4'd6;
  localparam logic [3:0] PAWN_BLACK   = 4'd9;
  localparam logic [3:0] ROOK_BLACK   = 4'd12;
  localparam logic [3:0] QUEEN_BLACK  = 4'd13;

  localparam int W = 21;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 new_game = 1'b0;
  logic                 click_btn = 1'b0;
  logic                 cursor_valid = 1'b0;
  logic [2:0]           cursor_squareX = 3'd0;
  logic [2:0]           cursor_squareY = 3'd0;

  logic [7:0][7:0][3:0] w_board, w_board_np;
  logic [2:0]           w_startX, w_startY, w_startX_np, w_startY_np;
  logic                 w_hl, w_hl_np, w_wt, w_wt_np, w_md, w_md_np;
  logic [1:0]           w_state, w_state_np;

  logic [W-1:0]         exp_q[$];
  logic [7:0][7:0][3:0] m_board, m_np;
  logic                 m_wt;
  int                   n_cmp = 0;
  int                   n_err = 0;

  move_controller #(.PROMOTE_EN(1'b1), .WHITE_FIRST(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .new_game(new_game), .click_btn(click_btn),
    .cursor_valid(cursor_valid), .cursor_squareX(cursor_squareX),
    .cursor_squareY(cursor_squareY), .board(w_board), .startX(w_startX),
    .startY(w_startY), .highlight_flag(w_hl), .white_turn(w_wt),
    .move_done(w_md), .o_state(w_state)
  );

  move_controller #(.PROMOTE_EN(1'b0), .WHITE_FIRST(1'b1)) dut_np (
    .Clk(Clk), .Reset(Reset), .new_game(new_game), .click_btn(click_btn),
    .cursor_valid(cursor_valid), .cursor_squareX(cursor_squareX),
    .cursor_squareY(cursor_squareY), .board(w_board_np), .startX(w_startX_np),
    .startY(w_startY_np), .highlight_flag(w_hl_np), .white_turn(w_wt_np),
    .move_done(w_md_np), .o_state(w_state_np)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0][7:0][3:0] start_board();
    logic [7:0][7:0][3:0] b;
    logic [3:0] rank [8];
    rank[0] = ROOK_WHITE;  rank[1] = KNIGHT_WHITE; rank[2] = BISHOP_WHITE;
    rank[3] = QUEEN_WHITE; rank[4] = KING_WHITE;   rank[5] = BISHOP_WHITE;
    rank[6] = KNIGHT_WHITE; rank[7] = ROOK_WHITE;
    b = '0;
    for (int x = 0; x < 8; x++) begin
      b[x][7] = rank[x];
      b[x][0] = rank[x] | 4'd8;
      b[x][6] = PAWN_WHITE;
      b[x][1] = PAWN_BLACK;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_board = start_board();
    m_np    = start_board();
    m_wt    = 1'b1;
  endtask

  task automatic check_board(input string tag);
    check({tag, "_board"}, w_board, m_board);
    check({tag, "_board_np"}, w_board_np, m_np);
    check({tag, "_turn"}, w_wt, m_wt);
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic click(input int x, input int y, input logic valid);
    @(negedge Clk);
    cursor_squareX = x[2:0];
    cursor_squareY = y[2:0];
    cursor_valid   = valid;
    click_btn      = 1'b1;
    @(negedge Clk);
    click_btn      = 1'b0;
  endtask

  task automatic push_move(input int sx, input int sy, input int dx, input int dy);
    logic [3:0] p, q, pn;
    p  = m_board[sx][sy];
    pn = m_np[sx][sy];
    q  = p;
    if (p == PAWN_WHITE && dy == 0) q = QUEEN_WHITE;
    if (p == PAWN_BLACK && dy == 7) q = QUEEN_BLACK;
    m_board[dx][dy] = q;  m_board[sx][sy] = EMPTY;
    m_np[dx][dy]    = pn; m_np[sx][sy]    = EMPTY;
    m_wt = ~m_wt;
    exp_q.push_back({sx[2:0], sy[2:0], dx[2:0], dy[2:0], q, pn, m_wt});
  endtask

  task automatic do_move(input int sx, input int sy, input int dx, input int dy);
    push_move(sx, sy, dx, dy);
    click(sx, sy, 1'b1);
    click(dx, dy, 1'b1);
    idle(2);
  endtask

  task automatic async_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check("areset_board", w_board, m_board);
    check("areset_hl", w_hl, 1'b0);
    check("areset_turn", w_wt, 1'b1);
    check("areset_md", w_md, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (w_md === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("md_unexpected", w_md, 1'b0);
      end else begin
        e = exp_q.pop_front();
        @(posedge Clk);
        #1;
        check("sb_dst", w_board[e[14:12]][e[11:9]], e[8:5]);
        check("sb_dst_np", w_board_np[e[14:12]][e[11:9]], e[4:1]);
        check("sb_src", w_board[e[20:18]][e[17:15]], EMPTY);
        check("sb_turn", w_wt, e[0]);
        check("sb_md_width", w_md, 1'b0);
        check("sb_hl", w_hl, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    idle(3);
    Reset = 1'b0;

    // Reset state
    check("rst_a8", w_board[0][0], ROOK_BLACK);
    check("rst_king", w_board[4][7], KING_WHITE);
    check("rst_pawn", w_board[3][6], PAWN_WHITE);
    check("rst_empty", w_board[3][3], EMPTY);
    check("rst_turn", w_wt, 1'b1);
    check("rst_hl", w_hl, 1'b0);
    check("rst_md", w_md, 1'b0);
    check("rst_start", {w_startX, w_startY}, 6'd0);
    check_board("rst");

    // Opponent piece and off-board clicks do nothing
    click(0, 1, 1'b1);
    check("opp_hl", w_hl, 1'b0);
    click(4, 6, 1'b0);
    check("invalid_hl", w_hl, 1'b0);
    click(3, 3, 1'b1);
    check("empty_hl", w_hl, 1'b0);
    check_board("noop");

    // Held button is a single event; deselect; reselect
    @(negedge Clk);
    cursor_squareX = 3'd1; cursor_squareY = 3'd7; cursor_valid = 1'b1; click_btn = 1'b1;
    idle(10);
    click_btn = 1'b0;
    check("hold_hl", w_hl, 1'b1);
    check("hold_start", {w_startX, w_startY}, {3'd1, 3'd7});
    click(1, 7, 1'b1);
    check("desel_hl", w_hl, 1'b0);
    click(1, 7, 1'b1);
    click(6, 7, 1'b1);
    check("resel_hl", w_hl, 1'b1);
    check("resel_start", {w_startX, w_startY}, {3'd6, 3'd7});
    click(6, 7, 1'b1);
    check("resel_desel", w_hl, 1'b0);
    check_board("sel");

    // Basic move e2-e4 style
    click(4, 6, 1'b1);
    check("mv_hl", w_hl, 1'b1);
    check("mv_start", {w_startX, w_startY}, {3'd4, 3'd6});
    push_move(4, 6, 4, 4);
    click(4, 4, 1'b1);
    idle(2);
    check("mv_dst", w_board[4][4], PAWN_WHITE);
    check("mv_src", w_board[4][6], EMPTY);
    check("mv_turn", w_wt, 1'b0);
    check_board("mv");

    // Black to move: a white piece is not selectable
    click(3, 6, 1'b1);
    check("turn_hl", w_hl, 1'b0);

    // Promotion both colours, captures by overwrite
    do_move(7, 1, 7, 2);
    do_move(0, 6, 0, 1);
    do_move(7, 2, 7, 3);
    do_move(0, 1, 0, 0);
    check("promo_w", w_board[0][0], QUEEN_WHITE);
    check("promo_w_off", w_board_np[0][0], PAWN_WHITE);
    do_move(1, 1, 1, 7);
    check("promo_b", w_board[1][7], QUEEN_BLACK);
    check("promo_b_off", w_board_np[1][7], PAWN_BLACK);
    check_board("promo");

    // Reset while SELECTED
    click(4, 6, 1'b1);
    async_reset();
    check("rsel_start", {w_startX, w_startY}, 6'd0);
    click(4, 4, 1'b1);
    check("rsel_idle_hl", w_hl, 1'b0);
    idle(2);
    check_board("rsel");

    // Reset while COMMIT
    click(4, 6, 1'b1);
    @(negedge Clk);
    cursor_squareX = 3'd4; cursor_squareY = 3'd4; click_btn = 1'b1;
    @(posedge Clk);
    #1;
    check("rcom_md", w_md, 1'b1);
    Reset = 1'b1;
    #1;
    check("rcom_md_clr", w_md, 1'b0);
    check("rcom_board", w_board, m_board);
    @(negedge Clk);
    click_btn = 1'b0;
    Reset = 1'b0;
    idle(2);
    check_board("rcom");

    // new_game coincident with a destination click
    do_move(4, 6, 4, 4);
    click(4, 1, 1'b1);
    check("ng_sel_hl", w_hl, 1'b1);
    @(negedge Clk);
    cursor_squareX = 3'd4; cursor_squareY = 3'd3; click_btn = 1'b1; new_game = 1'b1;
    @(negedge Clk);
    click_btn = 1'b0; new_game = 1'b0;
    model_reset();
    check("ng_hl", w_hl, 1'b0);
    check("ng_md", w_md, 1'b0);
    idle(2);
    check_board("ng");

    idle(4);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
